buzzer_tone_gen: RTL and testbench

//  Downstream of the auto-play sequencer: converts the 4-bit note code and 2-bit octave it emits

---
 rtl/buzzer_pkg.sv | 44 ++++
 rtl/note_half_period_lut.sv | 37 +++
 rtl/buzzer_tone_gen.sv | 117 +++++++++++
 tb/tb_buzzer_tone_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared note/octave codes, mid-octave frequency table and FSM encoding
// for the buzzer tone generator.
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_GAP    = 2'd1,
    ST_TONE   = 2'd2
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;
  localparam logic [1:0] OCT_ALT  = 2'd3;

  // Mid-octave frequencies in Hz; non-tonal codes map to 0.
  function automatic int unsigned f_mid(input logic [3:0] note);
    case (note)
      NOTE_DO:  return 262;
      NOTE_RE:  return 294;
      NOTE_MI:  return 330;
      NOTE_FA:  return 349;
      NOTE_SOL: return 392;
      NOTE_LA:  return 440;
      NOTE_SI:  return 494;
      default:  return 0;
    endcase
  endfunction

  function automatic logic is_tonal(input logic [3:0] note);
    return (note >= NOTE_DO) && (note <= NOTE_SI);
  endfunction

endpackage

// File: rtl/note_half_period_lut.sv
// Combinational {note, octave} -> half-period lookup in clock cycles.
// Returns 0 for rests, invalid codes and the end marker.
module note_half_period_lut
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 21
) (
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] half
);

  // Base table is folded to constants at elaboration; no runtime divider.
  function automatic logic [7:0][CNT_W-1:0] build_base();
    logic [7:0][CNT_W-1:0] tbl;
    tbl = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      tbl[i[2:0]] = CNT_W'(CLK_HZ / (2 * f_mid(4'(i))));
    end
    return tbl;
  endfunction

  localparam logic [7:0][CNT_W-1:0] BASE = build_base();

  always_comb begin
    half = '0;
    if (is_tonal(note)) begin
      case (octave)
        OCT_LOW:  half = BASE[note[2:0]] << 1;
        OCT_HIGH: half = BASE[note[2:0]] >> 1;
        default:  half = BASE[note[2:0]];
      endcase
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Note/octave to 50%-duty buzzer square wave, with a silent articulation
// gap inserted before every newly triggered tone.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       buzzer,
  output logic       tone_active,
  output logic [3:0] cur_note,
  output logic [1:0] cur_octave
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t           state;
  logic [5:0]       in_q;
  logic [5:0]       play_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] half;
  logic             change;
  logic             tonal;

  note_half_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note   (play_q[5:2]),
    .octave (play_q[1:0]),
    .half   (half)
  );

  assign change = (in_q != play_q);
  assign tonal  = is_tonal(in_q[5:2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SILENT;
      in_q        <= '0;
      play_q      <= '0;
      gap_cnt     <= '0;
      half_cnt    <= '0;
      buzzer      <= 1'b0;
      tone_active <= 1'b0;
      cur_note    <= '0;
      cur_octave  <= '0;
    end else begin
      in_q <= {note_in, octave_in};
      if (!enable) begin
        // Clearing play_q makes the held input look new again on re-enable.
        state       <= ST_SILENT;
        play_q      <= '0;
        buzzer      <= 1'b0;
        tone_active <= 1'b0;
        cur_note    <= '0;
        cur_octave  <= '0;
      end else if (change) begin
        play_q   <= in_q;
        gap_cnt  <= '0;
        half_cnt <= '0;
        if (tonal && (GAP_CYCLES == 0)) begin
          state       <= ST_TONE;
          buzzer      <= 1'b1;
          tone_active <= 1'b1;
          cur_note    <= in_q[5:2];
          cur_octave  <= in_q[1:0];
        end else begin
          state       <= tonal ? ST_GAP : ST_SILENT;
          buzzer      <= 1'b0;
          tone_active <= 1'b0;
          cur_note    <= '0;
          cur_octave  <= '0;
        end
      end else begin
        case (state)
          ST_SILENT: buzzer <= 1'b0;
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state       <= ST_TONE;
              buzzer      <= 1'b1;
              tone_active <= 1'b1;
              cur_note    <= play_q[5:2];
              cur_octave  <= play_q[1:0];
              half_cnt    <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          ST_TONE: begin
            if (half_cnt == half - CNT_W'(1)) begin
              buzzer   <= ~buzzer;
              half_cnt <= '0;
            end else begin
              half_cnt <= half_cnt + CNT_W'(1);
            end
          end
          default: begin
            state       <= ST_SILENT;
            buzzer      <= 1'b0;
            tone_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_HZ=1e6, GAP_CYCLES=4.
module tb_buzzer_tone_gen;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned GAP    = 4;
  localparam int unsigned CNT_W  = 21;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] note_in = 4'd0;
  logic [1:0] octave_in = 2'd0;
  logic       buzzer;
  logic       tone_active;
  logic [3:0] cur_note;
  logic [1:0] cur_octave;

  int unsigned checks = 0;
  int unsigned errors = 0;

  buzzer_tone_gen #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .note_in     (note_in),
    .octave_in   (octave_in),
    .buzzer      (buzzer),
    .tone_active (tone_active),
    .cur_note    (cur_note),
    .cur_octave  (cur_octave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; sample point sits 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    repeat (n) step();
  endtask

  // Number of edges until buzzer changes level, bounded.
  task automatic measure(input string tag, input int unsigned exp);
    logic        start;
    int unsigned n;
    start = buzzer;
    n = 0;
    while (buzzer === start && n < 5000) begin
      step();
      n++;
    end
    check(tag, n, exp);
  endtask

  // Input was just applied before edge k: expect gap at k+1..k+4, tone at k+5.
  task automatic retrigger(input string tag, input int unsigned exp_note,
                           input int unsigned exp_oct, input int unsigned exp_half);
    steps(2);
    check({tag, "_gap_buz"}, buzzer, 0);
    check({tag, "_gap_act"}, tone_active, 0);
    check({tag, "_gap_note"}, cur_note, 0);
    steps(3);
    check({tag, "_pre_buz"}, buzzer, 0);
    step();
    check({tag, "_on_buz"}, buzzer, 1);
    check({tag, "_on_act"}, tone_active, 1);
    check({tag, "_note"}, cur_note, exp_note);
    check({tag, "_oct"}, cur_octave, exp_oct);
    measure({tag, "_half_hi"}, exp_half);
    measure({tag, "_half_lo"}, exp_half);
  endtask

  initial begin
    // Reset held with A-mid applied.
    note_in   = 4'd6;
    octave_in = 2'd1;
    steps(5);
    check("rst_buz", buzzer, 0);
    check("rst_act", tone_active, 0);
    check("rst_note", cur_note, 0);
    check("rst_oct", cur_octave, 0);
    reset = 1'b1;
    retrigger("la_mid", 6, 1, 1136);

    octave_in = 2'd2;
    retrigger("la_high", 6, 2, 568);
    octave_in = 2'd0;
    retrigger("la_low", 6, 0, 2272);

    // End marker silences one edge after it is registered.
    note_in = 4'd15;
    step();
    step();
    check("end_buz", buzzer, 0);
    check("end_act", tone_active, 0);
    check("end_note", cur_note, 0);
    steps(50);
    check("end_hold_buz", buzzer, 0);
    check("end_hold_act", tone_active, 0);

    // Note 3 then note 5 inside the gap: gap restarts for note 5.
    note_in   = 4'd3;
    octave_in = 2'd1;
    steps(3);
    note_in = 4'd5;
    retrigger("sol_mid", 5, 1, 1275);
    for (int unsigned h = 0; h < 6; h++) begin
      measure("sol_hold_half", 1275);
    end
    check("sol_hold_act", tone_active, 1);
    check("sol_hold_note", cur_note, 5);

    // Mute mid-tone, then re-enable with the same note held.
    enable = 1'b0;
    step();
    check("mute_buz", buzzer, 0);
    check("mute_act", tone_active, 0);
    steps(10);
    enable = 1'b1;
    steps(4);
    check("reen_gap_buz", buzzer, 0);
    step();
    check("reen_on_buz", buzzer, 1);
    check("reen_note", cur_note, 5);
    measure("reen_half", 1275);

    // Invalid note code behaves as a rest.
    note_in = 4'd9;
    steps(10);
    check("inval_buz", buzzer, 0);
    check("inval_act", tone_active, 0);

    // Octave 3 uses the mid table: 1e6/(2*262) = 1908.
    note_in   = 4'd1;
    octave_in = 2'd3;
    retrigger("do_alt", 1, 3, 1908);

    // Async reset between edges while buzzer is high.
    while (buzzer !== 1'b1 && checks < 1000000) step();
    reset = 1'b0;
    #2;
    check("arst_buz", buzzer, 0);
    check("arst_act", tone_active, 0);
    check("arst_note", cur_note, 0);
    steps(3);
    reset = 1'b1;
    retrigger("arst_rel", 1, 3, 1908);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
